// File: rtl/timing_generator_cfg.sv
// Runtime-reconfigurable video timing generator: DE/HSYNC/VSYNC, active X/Y and frame/line markers.
// New timing is staged in a shadow set and swapped in only at the frame wrap.
module timing_generator_cfg #(
    parameter int unsigned CW     = 12,
    parameter int unsigned HAC_D  = 640,
    parameter int unsigned HFP_D  = 16,
    parameter int unsigned HSP_D  = 96,
    parameter int unsigned HBP_D  = 48,
    parameter int unsigned VAC_D  = 480,
    parameter int unsigned VFP_D  = 10,
    parameter int unsigned VSP_D  = 2,
    parameter int unsigned VBP_D  = 33,
    parameter bit          HS_POL = 1'b1,
    parameter bit          VS_POL = 1'b1
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_en,
    input  logic          i_cfg_load,
    input  logic [CW-1:0] i_hac,
    input  logic [CW-1:0] i_hfp,
    input  logic [CW-1:0] i_hsp,
    input  logic [CW-1:0] i_hbp,
    input  logic [CW-1:0] i_vac,
    input  logic [CW-1:0] i_vfp,
    input  logic [CW-1:0] i_vsp,
    input  logic [CW-1:0] i_vbp,
    output logic          o_de,
    output logic          o_hs,
    output logic          o_vs,
    output logic [CW-1:0] o_x,
    output logic [CW-1:0] o_y,
    output logic          o_sof,
    output logic          o_eol,
    output logic          o_cfg_pending,
    output logic          o_cfg_err
);

    localparam int unsigned   TW     = CW + 2;
    localparam logic [TW-1:0] MaxTot = TW'(2 ** CW);

    logic [CW-1:0] col_q, row_q;
    logic [CW-1:0] hac_q, hfp_q, hsp_q, hbp_q, vac_q, vfp_q, vsp_q, vbp_q;
    logic [CW-1:0] hac_s, hfp_s, hsp_s, hbp_s, vac_s, vfp_s, vsp_s, vbp_s;
    logic          pending_q;

    logic [TW-1:0] ht, vt, hs_beg, hs_end, vs_beg, vs_end, req_ht, req_vt;
    logic          hde, vde, hs_on, vs_on, col_last, row_last, wrap, load_ok;

    always_comb begin
        ht       = TW'(hac_q) + TW'(hfp_q) + TW'(hsp_q) + TW'(hbp_q);
        vt       = TW'(vac_q) + TW'(vfp_q) + TW'(vsp_q) + TW'(vbp_q);
        hs_beg   = TW'(hac_q) + TW'(hfp_q);
        hs_end   = hs_beg + TW'(hsp_q);
        vs_beg   = TW'(vac_q) + TW'(vfp_q);
        vs_end   = vs_beg + TW'(vsp_q);
        req_ht   = TW'(i_hac) + TW'(i_hfp) + TW'(i_hsp) + TW'(i_hbp);
        req_vt   = TW'(i_vac) + TW'(i_vfp) + TW'(i_vsp) + TW'(i_vbp);
        col_last = (TW'(col_q) == ht - TW'(1));
        row_last = (TW'(row_q) == vt - TW'(1));
        wrap     = col_last && row_last;
        hde      = (col_q < hac_q);
        vde      = (row_q < vac_q);
        hs_on    = (TW'(col_q) >= hs_beg) && (TW'(col_q) < hs_end);
        vs_on    = (TW'(row_q) >= vs_beg) && (TW'(row_q) < vs_end);
        // Totals may reach exactly 2^CW: the counters then run 0..2^CW-1.
        load_ok  = (i_hac != '0) && (i_hfp != '0) && (i_hsp != '0) && (i_hbp != '0) &&
                   (i_vac != '0) && (i_vfp != '0) && (i_vsp != '0) && (i_vbp != '0) &&
                   (req_ht <= MaxTot) && (req_vt <= MaxTot);
    end

    assign o_cfg_pending = pending_q;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            col_q     <= '0;
            row_q     <= '0;
            hac_q     <= CW'(HAC_D);
            hfp_q     <= CW'(HFP_D);
            hsp_q     <= CW'(HSP_D);
            hbp_q     <= CW'(HBP_D);
            vac_q     <= CW'(VAC_D);
            vfp_q     <= CW'(VFP_D);
            vsp_q     <= CW'(VSP_D);
            vbp_q     <= CW'(VBP_D);
            hac_s     <= '0;
            hfp_s     <= '0;
            hsp_s     <= '0;
            hbp_s     <= '0;
            vac_s     <= '0;
            vfp_s     <= '0;
            vsp_s     <= '0;
            vbp_s     <= '0;
            pending_q <= 1'b0;
            o_de      <= 1'b0;
            o_hs      <= !HS_POL;
            o_vs      <= !VS_POL;
            o_x       <= '0;
            o_y       <= '0;
            o_sof     <= 1'b0;
            o_eol     <= 1'b0;
            o_cfg_err <= 1'b0;
        end else begin
            o_cfg_err <= i_cfg_load && !load_ok;

            if (i_en) begin
                if (col_last) begin
                    col_q <= '0;
                    row_q <= row_last ? '0 : row_q + CW'(1);
                end else begin
                    col_q <= col_q + CW'(1);
                end
                // Apply sees the shadow as it was before any load in this same cycle.
                if (wrap && pending_q) begin
                    hac_q <= hac_s;
                    hfp_q <= hfp_s;
                    hsp_q <= hsp_s;
                    hbp_q <= hbp_s;
                    vac_q <= vac_s;
                    vfp_q <= vfp_s;
                    vsp_q <= vsp_s;
                    vbp_q <= vbp_s;
                end
                o_de  <= hde && vde;
                o_hs  <= (hs_on == HS_POL);
                o_vs  <= (vs_on == VS_POL);
                o_x   <= (hde && vde) ? col_q : hac_q - CW'(1);
                o_y   <= vde ? row_q : vac_q - CW'(1);
                o_sof <= (col_q == '0) && (row_q == '0);
                o_eol <= (col_q == hac_q - CW'(1)) && vde;
            end else begin
                o_de  <= 1'b0;
                o_hs  <= !HS_POL;
                o_vs  <= !VS_POL;
                o_sof <= 1'b0;
                o_eol <= 1'b0;
            end

            if (i_cfg_load && load_ok) begin
                hac_s     <= i_hac;
                hfp_s     <= i_hfp;
                hsp_s     <= i_hsp;
                hbp_s     <= i_hbp;
                vac_s     <= i_vac;
                vfp_s     <= i_vfp;
                vsp_s     <= i_vsp;
                vbp_s     <= i_vbp;
                pending_q <= 1'b1;
            end else if (i_en && wrap) begin
                pending_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_timing_generator_cfg.sv
// Bench for timing_generator_cfg: frame-position reference model checked every cycle,
// plus measured frame periods and per-frame DE/sync counts pinned to hand-computed values.
module tb_timing_generator_cfg;

    localparam bit HS_POL = 1'b0;
    localparam bit VS_POL = 1'b1;

    logic        clk = 1'b0;
    logic        rstn;
    logic        en;
    logic        load;
    logic [11:0] f [8];
    logic        o_de, o_hs, o_vs, o_sof, o_eol, o_cfg_pending, o_cfg_err;
    logic [11:0] o_x, o_y;

    always #5 clk = ~clk;

    timing_generator_cfg #(
        .CW(12), .HAC_D(16), .HFP_D(2), .HSP_D(3), .HBP_D(4),
        .VAC_D(6), .VFP_D(1), .VSP_D(2), .VBP_D(2),
        .HS_POL(HS_POL), .VS_POL(VS_POL)
    ) dut (
        .i_clk(clk), .i_rstn(rstn), .i_en(en), .i_cfg_load(load),
        .i_hac(f[0]), .i_hfp(f[1]), .i_hsp(f[2]), .i_hbp(f[3]),
        .i_vac(f[4]), .i_vfp(f[5]), .i_vsp(f[6]), .i_vbp(f[7]),
        .o_de(o_de), .o_hs(o_hs), .o_vs(o_vs), .o_x(o_x), .o_y(o_y),
        .o_sof(o_sof), .o_eol(o_eol), .o_cfg_pending(o_cfg_pending), .o_cfg_err(o_cfg_err)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: position inside the frame as a linear pixel index.
    int m_cfg [8];
    int m_sh  [8];
    bit m_pend;
    int m_pos;
    bit e_de, e_hs, e_vs, e_sof, e_eol, e_err;
    int e_x, e_y;
    int fl [8];
    int m_ht, m_vt, req_h, req_v, c, r;
    bit ok;

    function automatic int cur_total();
        return (m_cfg[0] + m_cfg[1] + m_cfg[2] + m_cfg[3]) *
               (m_cfg[4] + m_cfg[5] + m_cfg[6] + m_cfg[7]);
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_cfg  = '{16, 2, 3, 4, 6, 1, 2, 2};
            m_sh   = '{0, 0, 0, 0, 0, 0, 0, 0};
            m_pend = 1'b0;
            m_pos  = 0;
            e_de = 0; e_hs = !HS_POL; e_vs = !VS_POL; e_sof = 0; e_eol = 0; e_err = 0;
            e_x = 0; e_y = 0;
        end else begin
            for (int i = 0; i < 8; i++) fl[i] = int'(f[i]);
            req_h = fl[0] + fl[1] + fl[2] + fl[3];
            req_v = fl[4] + fl[5] + fl[6] + fl[7];
            ok = (req_h <= 4096) && (req_v <= 4096);
            for (int i = 0; i < 8; i++) if (fl[i] == 0) ok = 1'b0;
            e_err = load && !ok;
            if (en) begin
                m_ht = m_cfg[0] + m_cfg[1] + m_cfg[2] + m_cfg[3];
                m_vt = m_cfg[4] + m_cfg[5] + m_cfg[6] + m_cfg[7];
                c = m_pos % m_ht;
                r = m_pos / m_ht;
                e_de  = (c < m_cfg[0]) && (r < m_cfg[4]);
                e_hs  = ((c >= m_cfg[0] + m_cfg[1]) && (c < m_cfg[0] + m_cfg[1] + m_cfg[2]))
                        ? HS_POL : !HS_POL;
                e_vs  = ((r >= m_cfg[4] + m_cfg[5]) && (r < m_cfg[4] + m_cfg[5] + m_cfg[6]))
                        ? VS_POL : !VS_POL;
                e_x   = e_de ? c : m_cfg[0] - 1;
                e_y   = (r < m_cfg[4]) ? r : m_cfg[4] - 1;
                e_sof = (m_pos == 0);
                e_eol = (c == m_cfg[0] - 1) && (r < m_cfg[4]);
                if (m_pos == m_ht * m_vt - 1) begin
                    m_pos = 0;
                    if (m_pend) begin
                        m_cfg  = m_sh;
                        m_pend = 1'b0;
                    end
                end else begin
                    m_pos++;
                end
            end else begin
                e_de = 0; e_hs = !HS_POL; e_vs = !VS_POL; e_sof = 0; e_eol = 0;
            end
            if (load && ok) begin
                m_sh   = fl;
                m_pend = 1'b1;
            end
        end
    end

    bit run = 1'b0;

    always @(negedge clk) begin
        if (run) begin
            check("de", o_de, e_de);
            check("hs", o_hs, e_hs);
            check("vs", o_vs, e_vs);
            check("x", o_x, e_x);
            check("y", o_y, e_y);
            check("sof", o_sof, e_sof);
            check("eol", o_eol, e_eol);
            check("pending", o_cfg_pending, m_pend);
            check("cfg_err", o_cfg_err, e_err);
        end
    end

    // Per-frame measurements, finalised on each SOF.
    int cyc = 0, last_sof = 0, last_period = 0;
    int de_acc = 0, hs_acc = 0, vs_acc = 0, last_de = 0, last_hs = 0, last_vs = 0;

    always @(negedge clk) begin
        cyc++;
        if (o_sof) begin
            last_period = cyc - last_sof;
            last_sof    = cyc;
            last_de = de_acc; last_hs = hs_acc; last_vs = vs_acc;
            de_acc = 0; hs_acc = 0; vs_acc = 0;
        end
        if (o_de) de_acc++;
        if (o_hs == HS_POL) hs_acc++;
        if (o_vs == VS_POL) vs_acc++;
    end

    task automatic wait_sof(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            #1;
            seen = o_sof;
        end
        if (!seen) check("sof_timeout", 0, 1);
    endtask

    task automatic do_load(input int a0, input int a1, input int a2, input int a3,
                           input int b0, input int b1, input int b2, input int b3);
        f[0] = 12'(a0); f[1] = 12'(a1); f[2] = 12'(a2); f[3] = 12'(a3);
        f[4] = 12'(b0); f[5] = 12'(b1); f[6] = 12'(b2); f[7] = 12'(b3);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    int  pend_before;
    bit  hit;

    initial begin
        rstn = 1'b0; en = 1'b0; load = 1'b0;
        for (int i = 0; i < 8; i++) f[i] = '0;
        repeat (3) @(negedge clk);
        run = 1'b1;
        check("rst_hs", o_hs, 1);
        check("rst_vs", o_vs, 0);
        check("rst_de", o_de, 0);
        check("rst_x", o_x, 0);
        rstn = 1'b1;
        en   = 1'b1;

        // Default 25x11 frame.
        wait_sof(400); wait_sof(400); wait_sof(400);
        check("def_period", last_period, 275);
        check("def_de", last_de, 96);
        check("def_hs", last_hs, 33);
        check("def_vs", last_vs, 50);

        // 37-cycle enable gap mid-frame.
        repeat (30) @(negedge clk);
        en = 1'b0;
        repeat (37) @(negedge clk);
        en = 1'b1;
        wait_sof(400);
        check("gap_period", last_period, 312);
        check("gap_de", last_de, 96);

        // Rejected loads: a zero field, then HT = 4097.
        pend_before = int'(o_cfg_pending);
        do_load(16, 2, 0, 4, 6, 1, 2, 2);
        check("err_zero", o_cfg_err, 1);
        check("err_zero_pend", o_cfg_pending, pend_before);
        @(negedge clk);
        check("err_one_cycle", o_cfg_err, 0);
        do_load(4000, 50, 40, 7, 6, 1, 2, 2);
        check("err_ht4097", o_cfg_err, 1);
        check("err_ht_pend", o_cfg_pending, pend_before);

        // Randomised enables and loads, checked against the model every cycle.
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            en   = ($urandom_range(0, 9) != 0);
            load = ($urandom_range(0, 19) == 0);
            for (int i = 0; i < 8; i++) f[i] = 12'($urandom_range(1, 8));
            if ($urandom_range(0, 3) == 0) f[$urandom_range(0, 7)] = '0;
            else if ($urandom_range(0, 7) == 0) f[0] = 12'd4095;
        end
        @(negedge clk);
        en = 1'b1; load = 1'b0;

        // Staged config applies only at the wrap.
        do_load(8, 1, 2, 1, 3, 1, 1, 1);
        check("a_pending", o_cfg_pending, 1);
        wait_sof(2000);
        check("a_applied", o_cfg_pending, 0);
        wait_sof(200);
        check("a_period", last_period, 72);

        // Load B, then load C in the very cycle of the wrap that applies B.
        do_load(6, 2, 2, 2, 4, 1, 1, 2);
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            hit = (m_pos == cur_total() - 1);
        end
        if (!hit) check("wrap_timeout", 0, 1);
        do_load(10, 1, 1, 1, 5, 1, 1, 1);
        check("bc_pending", o_cfg_pending, 1);
        wait_sof(200);
        wait_sof(200);
        check("b_period", last_period, 96);
        check("c_pending_cleared", o_cfg_pending, 0);
        wait_sof(200);
        check("c_period", last_period, 104);

        // Largest legal line: HT = 4096.
        do_load(4090, 2, 2, 2, 1, 1, 1, 1);
        wait_sof(400);
        wait_sof(20000);
        check("big_period", last_period, 16384);

        // Reset mid-frame with a load pending discards it.
        do_load(6, 2, 2, 2, 4, 1, 1, 2);
        repeat (500) @(negedge clk);
        #2 rstn = 1'b0;
        @(negedge clk);
        check("mid_rst_pending", o_cfg_pending, 0);
        check("mid_rst_hs", o_hs, 1);
        check("mid_rst_y", o_y, 0);
        rstn = 1'b1;
        wait_sof(400);
        wait_sof(400);
        check("post_rst_period", last_period, 275);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
